// File: rtl/main_mem_loader_if.sv
// Channel-0 slave memory port and start/done handshake between the loader and the HLS top `main`.
interface main_mem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 7
);
  logic              S_oe_ram;
  logic              S_we_ram;
  logic [ADDR_W-1:0] S_addr_ram;
  logic [DATA_W-1:0] S_Wdata_ram;
  logic [SIZE_W-1:0] S_data_ram_size;
  logic              Sout_DataRdy;
  logic              start_port;
  logic              done_port;

  modport master (
    output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port,
    input  Sout_DataRdy, done_port
  );

  modport slave (
    input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port,
    output Sout_DataRdy, done_port
  );
endinterface

// File: rtl/main_mem_loader.sv
// Loads a little-endian byte image into `main` through slave channel 0, then starts it and times the run.
// Optional watchdog on the ready/done waits: define MAIN_MEM_LOADER_WATCHDOG_EN.
module main_mem_loader #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 64,
  parameter int SIZE_W      = 7,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              base_valid,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  main_mem_loader_if.master mem,
  output logic [CNT_W-1:0]  sim_cycles,
  output logic              run_done,
  output logic              error
);
  localparam int NBYTES = DATA_W / 8;
  localparam int N_W    = $clog2(NBYTES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_WRITE    = 3'd2;
  localparam logic [2:0] S_WAIT_RDY = 3'd3;
  localparam logic [2:0] S_START    = 3'd4;
  localparam logic [2:0] S_RUN      = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  if (((DATA_W % 8) != 0) || (WDOG_CYCLES < 1)) begin : g_bad_param
    $error("main_mem_loader: DATA_W must be a multiple of 8 and WDOG_CYCLES >= 1");
  end

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] word_q;
  logic [N_W-1:0]    n_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wdog_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef MAIN_MEM_LOADER_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q;

  // Counts cycles spent in the current wait state; restarts on every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else if ((state_q == S_WAIT_RDY) || (state_q == S_RUN)) begin
      wdog_q <= wdog_q + WD_W'(1);
    end else begin
      wdog_q <= '0;
    end
  end

  assign wdog_hit = (wdog_q == WD_W'(WDOG_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  assign byte_ready          = (state_q == S_COLLECT);
  assign mem.S_oe_ram        = 1'b0;
  assign mem.S_we_ram        = (state_q == S_WRITE);
  assign mem.S_addr_ram      = (state_q == S_WRITE) ? addr_q : '0;
  assign mem.S_Wdata_ram     = (state_q == S_WRITE) ? word_q : '0;
  assign mem.S_data_ram_size = (state_q == S_WRITE) ? SIZE_W'({n_q, 3'b000}) : '0;
  assign mem.start_port      = (state_q == S_START);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      n_q        <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      sim_cycles <= '0;
      run_done   <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (byte_valid && (state_q == S_IDLE)) error <= 1'b1;
          if (base_valid) begin
            addr_q     <= base_addr;
            word_q     <= '0;
            n_q        <= '0;
            last_q     <= 1'b0;
            run_done   <= 1'b0;
            sim_cycles <= '0;
            state_q    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (byte_valid) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (n_q == N_W'(i)) word_q[8*i +: 8] <= byte_data;
            end
            n_q <= n_q + N_W'(1);
            if (byte_last || (n_q == N_W'(NBYTES - 1))) begin
              last_q  <= byte_last;
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: state_q <= S_WAIT_RDY;
        S_WAIT_RDY: begin
          if (mem.Sout_DataRdy) begin
            addr_q  <= addr_q + ADDR_W'(n_q);
            n_q     <= '0;
            word_q  <= '0;
            state_q <= last_q ? S_START : S_COLLECT;
          end else if (wdog_hit) begin
            error      <= 1'b1;
            run_done   <= 1'b1;
            sim_cycles <= '1;
            state_q    <= S_DONE;
          end
        end
        S_START: begin
          cnt_q <= CNT_W'(1);
          if (mem.done_port) begin
            sim_cycles <= CNT_W'(1);
            run_done   <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            state_q <= S_RUN;
          end
        end
        // cnt_q holds the cycles already elapsed; the current RUN cycle adds one more.
        S_RUN: begin
          if (mem.done_port) begin
            sim_cycles <= sat_inc(cnt_q);
            run_done   <= 1'b1;
            state_q    <= S_DONE;
          end else if (wdog_hit) begin
            error      <= 1'b1;
            run_done   <= 1'b1;
            sim_cycles <= '1;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_main_mem_loader.sv
// Directed bench for main_mem_loader: image loads, partial tail, address wrap, run timing, reset, watchdog.
module tb_main_mem_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 7;
  localparam int CNT_W  = 32;
  localparam int WDOG   = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              base_valid = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_last = 1'b0;
  logic              byte_ready;
  logic [CNT_W-1:0]  sim_cycles;
  logic              run_done;
  logic              error;

  main_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) mem_if();

  main_mem_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .CNT_W(CNT_W), .WDOG_CYCLES(WDOG)
  ) dut (
    .clock(clock), .reset(reset),
    .base_valid(base_valid), .base_addr(base_addr),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .mem(mem_if),
    .sim_cycles(sim_cycles), .run_done(run_done), .error(error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Write/start recorder and DataRdy responder, both working on the falling edge.
  logic [ADDR_W-1:0] wr_addr [64];
  logic [DATA_W-1:0] wr_data [64];
  logic [SIZE_W-1:0] wr_size [64];
  int wr_n = 0;
  int start_n = 0;
  int rdy_cyc = 0;
  int rcnt = 0;
  int rdy_lat = 2;
  bit rdy_en = 1'b1;
  logic done_drv = 1'b0;
  assign mem_if.done_port = done_drv;

  always @(negedge clock) begin
    if (mem_if.S_we_ram) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = mem_if.S_addr_ram;
        wr_data[wr_n] = mem_if.S_Wdata_ram;
        wr_size[wr_n] = mem_if.S_data_ram_size;
      end
      wr_n++;
    end
    if (mem_if.start_port) start_n++;
    if (reset) begin
      rcnt = 0;
      mem_if.Sout_DataRdy = 1'b0;
    end else begin
      mem_if.Sout_DataRdy = 1'b0;
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          mem_if.Sout_DataRdy = 1'b1;
          rdy_cyc = cyc;
        end
      end
      if (mem_if.S_we_ram && rdy_en) rcnt = rdy_lat;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bytes(input logic [7:0] first, input int count);
    for (int i = 0; i < count; i++) begin
      int w = 0;
      while (!byte_ready && w < 50) begin
        tick();
        w++;
      end
      if (!byte_ready) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: byte %0d not accepted, byte_ready=%b required 1", i, byte_ready);
        return;
      end
      byte_valid = 1'b1;
      byte_data  = 8'(first + 8'(i));
      byte_last  = (i == count - 1);
      tick();
      byte_valid = 1'b0;
      byte_last  = 1'b0;
    end
  endtask

  task automatic load(input logic [ADDR_W-1:0] b, input logic [7:0] first, input int count);
    base_valid = 1'b1;
    base_addr  = b;
    tick();
    base_valid = 1'b0;
    send_bytes(first, count);
  endtask

  task automatic wait_start();
    int w = 0;
    while (!mem_if.start_port && w < 100) begin
      tick();
      w++;
    end
    if (!mem_if.start_port) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: start_port=%b required 1", mem_if.start_port);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    checks++;
    if ({byte_ready, mem_if.S_oe_ram, mem_if.S_we_ram, mem_if.start_port, run_done, error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {byte_ready, mem_if.S_oe_ram, mem_if.S_we_ram, mem_if.start_port, run_done, error});
    end
    checks++;
    if ({mem_if.S_addr_ram, mem_if.S_Wdata_ram, mem_if.S_data_ram_size} !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h size=%0d required 0",
               mem_if.S_addr_ram, mem_if.S_Wdata_ram, mem_if.S_data_ram_size);
    end
    checks++;
    if (sim_cycles !== '0) begin
      errors++;
      $display("FAIL reset_sim_cycles: got %0d required 0", sim_cycles);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({byte_ready, mem_if.S_we_ram, mem_if.start_port, run_done, error} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required 00000",
               {byte_ready, mem_if.S_we_ram, mem_if.start_port, run_done, error});
    end
  endtask

  task automatic test_idle_byte_error();
    int w0 = wr_n;
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    tick();
    byte_valid = 1'b0;
    tick(2);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL idle_byte_error: error=%b required 1", error);
    end
    checks++;
    if ((wr_n - w0) != 0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_byte_dropped: writes=%0d byte_ready=%b required 0 and 0", wr_n - w0, byte_ready);
    end
  endtask

  task automatic test_full_word_and_count();
    int w0 = wr_n;
    int s0 = start_n;
    rdy_en = 1'b1;
    rdy_lat = 2;
    load(8'h10, 8'h01, 8);
    wait_start();
    checks++;
    if (cyc - rdy_cyc != 1) begin
      errors++;
      $display("FAIL start_after_rdy: gap=%0d required 1", cyc - rdy_cyc);
    end
    tick(5);
    done_drv = 1'b1;
    tick();
    done_drv = 1'b0;
    checks++;
    if (wr_n - w0 != 1) begin
      errors++;
      $display("FAIL full_write_count: got %0d required 1", wr_n - w0);
    end
    checks++;
    if (wr_addr[w0] !== 8'h10 || wr_size[w0] !== 7'd64) begin
      errors++;
      $display("FAIL full_addr_size: addr=%h size=%0d required 10 and 64", wr_addr[w0], wr_size[w0]);
    end
    checks++;
    if (wr_data[w0] !== 64'h0807060504030201) begin
      errors++;
      $display("FAIL full_data: got %h required 0807060504030201", wr_data[w0]);
    end
    checks++;
    if (sim_cycles !== 32'd6 || run_done !== 1'b1) begin
      errors++;
      $display("FAIL cycle_count: sim_cycles=%0d run_done=%b required 6 and 1", sim_cycles, run_done);
    end
    tick(4);
    checks++;
    if (sim_cycles !== 32'd6 || run_done !== 1'b1 || start_n - s0 != 1) begin
      errors++;
      $display("FAIL done_hold: sim_cycles=%0d run_done=%b starts=%0d required 6, 1, 1",
               sim_cycles, run_done, start_n - s0);
    end
  endtask

  task automatic test_partial_tail();
    int w0 = wr_n;
    base_valid = 1'b1;
    base_addr  = 8'h00;
    tick();
    base_valid = 1'b0;
    checks++;
    if (run_done !== 1'b0 || sim_cycles !== '0) begin
      errors++;
      $display("FAIL new_base_clears: run_done=%b sim_cycles=%0d required 0 and 0", run_done, sim_cycles);
    end
    send_bytes(8'hA0, 11);
    wait_start();
    done_drv = 1'b1;
    tick();
    done_drv = 1'b0;
    checks++;
    if (wr_n - w0 != 2) begin
      errors++;
      $display("FAIL tail_write_count: got %0d required 2", wr_n - w0);
    end
    checks++;
    if (wr_addr[w0] !== 8'h00 || wr_size[w0] !== 7'd64 || wr_data[w0] !== 64'hA7A6A5A4A3A2A1A0) begin
      errors++;
      $display("FAIL tail_write1: addr=%h size=%0d data=%h required 00, 64, a7a6a5a4a3a2a1a0",
               wr_addr[w0], wr_size[w0], wr_data[w0]);
    end
    checks++;
    if (wr_addr[w0+1] !== 8'h08 || wr_size[w0+1] !== 7'd24 || wr_data[w0+1] !== 64'h0000000000AAA9A8) begin
      errors++;
      $display("FAIL tail_write2: addr=%h size=%0d data=%h required 08, 24, 0000000000aaa9a8",
               wr_addr[w0+1], wr_size[w0+1], wr_data[w0+1]);
    end
    checks++;
    if (sim_cycles !== 32'd1 || run_done !== 1'b1) begin
      errors++;
      $display("FAIL done_with_start: sim_cycles=%0d run_done=%b required 1 and 1", sim_cycles, run_done);
    end
  endtask

  task automatic test_addr_wrap();
    int w0 = wr_n;
    load(8'hFC, 8'h11, 9);
    wait_start();
    tick(2);
    done_drv = 1'b1;
    tick();
    done_drv = 1'b0;
    checks++;
    if (wr_n - w0 != 2 || wr_addr[w0] !== 8'hFC || wr_size[w0] !== 7'd64) begin
      errors++;
      $display("FAIL wrap_write1: writes=%0d addr=%h size=%0d required 2, fc, 64",
               wr_n - w0, wr_addr[w0], wr_size[w0]);
    end
    checks++;
    if (wr_addr[w0+1] !== 8'h04 || wr_size[w0+1] !== 7'd8 || wr_data[w0+1] !== 64'h19) begin
      errors++;
      $display("FAIL wrap_write2: addr=%h size=%0d data=%h required 04, 8, 19",
               wr_addr[w0+1], wr_size[w0+1], wr_data[w0+1]);
    end
    checks++;
    if (sim_cycles !== 32'd3) begin
      errors++;
      $display("FAIL wrap_cycles: sim_cycles=%0d required 3", sim_cycles);
    end
  endtask

  task automatic test_reset_wait_rdy();
    int w0 = wr_n;
    rdy_en = 1'b0;
    load(8'h20, 8'h30, 8);
    tick(2);
    checks++;
    if (wr_n - w0 != 1 || error !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: writes=%0d error=%b required 1 and 1", wr_n - w0, error);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({byte_ready, mem_if.S_we_ram, mem_if.start_port, run_done, error, sim_cycles} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: ready=%b we=%b start=%b run_done=%b error=%b sim=%0d required all 0",
               byte_ready, mem_if.S_we_ram, mem_if.start_port, run_done, error, sim_cycles);
    end
    tick(3);
    reset = 1'b0;
    rdy_en = 1'b1;
    tick(6);
    checks++;
    if (wr_n - w0 != 1) begin
      errors++;
      $display("FAIL no_we_after_reset: writes=%0d required 1", wr_n - w0);
    end
    load(8'h40, 8'h50, 8);
    wait_start();
    tick();
    done_drv = 1'b1;
    tick();
    done_drv = 1'b0;
    checks++;
    if (wr_n - w0 != 2 || wr_addr[w0+1] !== 8'h40 || wr_data[w0+1] !== 64'h5756555453525150) begin
      errors++;
      $display("FAIL fresh_load: writes=%0d addr=%h data=%h required 2, 40, 5756555453525150",
               wr_n - w0, wr_addr[w0+1], wr_data[w0+1]);
    end
    checks++;
    if (sim_cycles !== 32'd2 || run_done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL fresh_run: sim=%0d run_done=%b error=%b required 2, 1, 0", sim_cycles, run_done, error);
    end
  endtask

`ifdef MAIN_MEM_LOADER_WATCHDOG_EN
  task automatic test_watchdog();
    int w = 0;
    rdy_en = 1'b0;
    load(8'h00, 8'h01, 8);
    while (!run_done && w < 60) begin
      tick();
      w++;
    end
    checks++;
    if (error !== 1'b1 || run_done !== 1'b1 || sim_cycles !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL watchdog: error=%b run_done=%b sim=%h required 1, 1, ffffffff",
               error, run_done, sim_cycles);
    end
    rdy_en = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, time=%0t required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_byte_error();
    test_full_word_and_count();
    test_partial_tail();
    test_addr_wrap();
    test_reset_wait_rdy();
`ifdef MAIN_MEM_LOADER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
